// File: rtl/alu_isa_pkg.sv
// rtl/alu_isa_pkg.sv - instruction field layout, MemOp codes and sequencer states
package alu_isa_pkg;

    localparam int INSTR_W   = 16;
    localparam int A_LSB     = 0;
    localparam int B_LSB     = 2;
    localparam int OP_LSB    = 4;
    localparam int ADDR_LSB  = 7;
    localparam int MEMOP_LSB = 11;
    localparam int HALT_BIT  = 14;
    localparam int RSVD_BIT  = 15;

    localparam logic [2:0] MEMOP_NONE  = 3'b000;
    localparam logic [2:0] MEMOP_STORE = 3'b001;
    localparam logic [2:0] MEMOP_LOAD  = 3'b010;

    localparam logic [2:0] NOP_OP_DEFAULT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [2:0] memop;
        logic [3:0] addr;
        logic [2:0] op;
        logic [1:0] b;
        logic [1:0] a;
    } alu_fields_t;

    function automatic alu_fields_t decode_fields(input logic [INSTR_W-1:0] w);
        alu_fields_t f;
        f.a     = w[A_LSB     +: 2];
        f.b     = w[B_LSB     +: 2];
        f.op    = w[OP_LSB    +: 3];
        f.addr  = w[ADDR_LSB  +: 4];
        f.memop = w[MEMOP_LSB +: 3];
        return f;
    endfunction

    function automatic alu_fields_t nop_bubble(input logic [2:0] nop_op);
        alu_fields_t f;
        f.a     = 2'd0;
        f.b     = 2'd0;
        f.op    = nop_op;
        f.addr  = 4'd0;
        f.memop = MEMOP_NONE;
        return f;
    endfunction

endpackage

// File: rtl/alu_prog_mem.sv
// rtl/alu_prog_mem.sv - program store: synchronous write, combinational read, no reset
module alu_prog_mem
    import alu_isa_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [AW-1:0]      i_waddr,
    input  logic [INSTR_W-1:0] i_wdata,
    input  logic [AW-1:0]      i_raddr,
    output logic [INSTR_W-1:0] o_rdata
);

    logic [INSTR_W-1:0] r_mem [2**AW];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/alu_issue_sequencer.sv
// rtl/alu_issue_sequencer.sv - walks the program store from 0 and issues one
// instruction per unheld cycle to the ALU stage until HALT or the last location.
module alu_issue_sequencer
    import alu_isa_pkg::*;
#(
    parameter int         PROG_AW = 4,
    parameter logic [2:0] NOP_OP  = NOP_OP_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_we,
    input  logic [PROG_AW-1:0] prog_addr,
    input  logic [15:0]        prog_data,
    input  logic               start,
    input  logic               hold,
    output logic [1:0]         A,
    output logic [1:0]         B,
    output logic [2:0]         Op,
    output logic [3:0]         Address,
    output logic [2:0]         MemOp,
    output logic               issue_valid,
    output logic               busy,
    output logic               done
);

    localparam logic [PROG_AW-1:0] PC_LAST = '1;

    seq_state_e         r_state;
    seq_state_e         w_state_nxt;
    logic [PROG_AW-1:0] r_pc;
    logic [PROG_AW-1:0] w_pc_nxt;
    logic               w_issue;
    logic               w_mem_we;
    logic [INSTR_W-1:0] w_word;
    alu_fields_t        r_fields;
    logic               r_issue_valid;
    logic               w_unused_rsvd;

    alu_prog_mem #(
        .AW (PROG_AW)
    ) u_prog_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (prog_addr),
        .i_wdata (prog_data),
        .i_raddr (r_pc),
        .o_rdata (w_word)
    );

    assign w_unused_rsvd = w_word[RSVD_BIT];

    // The store is only writable while idle so a running program cannot be patched underneath itself.
    assign w_mem_we = prog_we && (r_state == ST_IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = '0;
                end
            end
            ST_RUN: begin
                if (!hold) begin
                    if (w_word[HALT_BIT]) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_issue = 1'b1;
                        // Running off the end terminates the program rather than wrapping.
                        if (r_pc == PC_LAST) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_pc_nxt = r_pc + 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || !w_issue) begin
            r_fields      <= nop_bubble(NOP_OP);
            r_issue_valid <= 1'b0;
        end else begin
            r_fields      <= decode_fields(w_word);
            r_issue_valid <= 1'b1;
        end
    end

    assign A           = r_fields.a;
    assign B           = r_fields.b;
    assign Op          = r_fields.op;
    assign Address     = r_fields.addr;
    assign MemOp       = r_fields.memop;
    assign issue_valid = r_issue_valid;
    assign busy        = (r_state == ST_RUN);
    assign done        = (r_state == ST_DONE);

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// tb/tb_alu_issue_sequencer.sv - scoreboard bench for alu_issue_sequencer
module tb_alu_issue_sequencer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [15:0] prog_data;
    logic        start;
    logic        hold;
    logic [1:0]  A, B;
    logic [2:0]  Op, MemOp;
    logic [3:0]  Address;
    logic        issue_valid, busy, done;

    always #5 clk = ~clk;

    alu_issue_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .start       (start),
        .hold        (hold),
        .A           (A),
        .B           (B),
        .Op          (Op),
        .Address     (Address),
        .MemOp       (MemOp),
        .issue_valid (issue_valid),
        .busy        (busy),
        .done        (done)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          done_cnt = 0;
    int          issue_cnt = 0;
    logic        prev_done = 1'b0;
    logic [15:0] model_mem [DEPTH];
    logic [15:0] exp_q [$];
    logic [15:0] mon_w;

    task automatic check(input string name, input bit ok, input string detail);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (issue_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_issue", 1'b0,
                          $sformatf("issue Op=%0d A=%0d B=%0d seen, required no issue", Op, A, B));
                end else begin
                    mon_w = exp_q.pop_front();
                    issue_cnt++;
                    check("issue_fields",
                          {MemOp, Address, Op, B, A} ==
                          {mon_w[13:11], mon_w[10:7], mon_w[6:4], mon_w[3:2], mon_w[1:0]},
                          $sformatf("got memop=%0d addr=%0d op=%0d b=%0d a=%0d, required memop=%0d addr=%0d op=%0d b=%0d a=%0d",
                                    MemOp, Address, Op, B, A,
                                    mon_w[13:11], mon_w[10:7], mon_w[6:4], mon_w[3:2], mon_w[1:0]));
                end
            end else begin
                check("bubble", {A, B, Op, Address, MemOp} == {2'd0, 2'd0, 3'b111, 4'd0, 3'd0},
                      $sformatf("got a=%0d b=%0d op=%0d addr=%0d memop=%0d, required 0 0 7 0 0",
                                A, B, Op, Address, MemOp));
            end
            if (done) begin
                done_cnt++;
                check("done_single", !prev_done, "done high 2 cycles, required 1");
                check("done_not_busy", !busy, "busy=1 with done, required 0");
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        check(name, {A, B, Op, Address, MemOp, issue_valid, busy, done} ==
                    {2'd0, 2'd0, 3'b111, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0},
              $sformatf("got a=%0d b=%0d op=%0d addr=%0d memop=%0d v=%0d busy=%0d done=%0d, required 0 0 7 0 0 0 0 0",
                        A, B, Op, Address, MemOp, issue_valid, busy, done));
    endtask

    task automatic write_word(input int addr, input logic [15:0] data);
        prog_we   = 1'b1;
        prog_addr = 4'(addr);
        prog_data = data;
        model_mem[addr] = data;
        tick();
        prog_we = 1'b0;
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        w = 16'($urandom);
        w[14] = 1'b0;
        return w;
    endfunction

    // Expected issue stream: locations from 0 up to (not including) the first HALT, or all of them.
    task automatic push_expected();
        for (int i = 0; i < DEPTH; i++) begin
            if (model_mem[i][14]) break;
            exp_q.push_back(model_mem[i]);
        end
    endtask

    task automatic wait_done(input int hold_pct, input bit start_on_done);
        int d0;
        int n;
        int i0;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < 300) begin
            hold = (hold_pct > 0) && ($urandom_range(99) < hold_pct);
            tick();
            n++;
        end
        hold = 1'b0;
        check("done_seen", done_cnt == d0 + 1,
              $sformatf("done pulses=%0d within budget, required 1", done_cnt - d0));
        check("queue_drained", exp_q.size() == 0,
              $sformatf("%0d expected issues missing, required 0", exp_q.size()));
        if (start_on_done) begin
            i0 = issue_cnt;
            start = 1'b1;
            tick();
            start = 1'b0;
            repeat (3) tick();
            check("no_restart_from_done", !busy && issue_cnt == i0,
                  $sformatf("busy=%0d extra issues=%0d, required 0 0", busy, issue_cnt - i0));
        end
        exp_q.delete();
    endtask

    task automatic run_program(input int hold_pct, input bit start_on_done);
        push_expected();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(hold_pct, start_on_done);
        tick();
    endtask

    initial begin
        int i0;
        int len;
        logic [15:0] w;
        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0; start = 1'b0; hold = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 16'h4000;
        repeat (3) tick();
        check_idle("reset_state");
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) write_word(i, 16'h4000);

        // Single ADD then HALT, with first-issue latency checked explicitly.
        write_word(0, 16'((1 << 11) | (3 << 7) | (0 << 4) | (2 << 2) | 1));
        write_word(1, 16'h4000);
        push_expected();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("run_entry", busy && !issue_valid,
              $sformatf("busy=%0d valid=%0d after start edge, required 1 0", busy, issue_valid));
        tick();
        check("first_issue_latency", issue_valid == 1'b1,
              $sformatf("valid=%0d one edge after RUN entry, required 1", issue_valid));
        wait_done(0, 1'b1);
        tick();
        check_idle("idle_after_add");

        // Full store without HALT: 16 issues, no wrap.
        for (int i = 0; i < DEPTH; i++) write_word(i, rand_word());
        i0 = issue_cnt;
        run_program(0, 1'b0);
        check("full_store_count", issue_cnt - i0 == 16,
              $sformatf("issued %0d, required 16", issue_cnt - i0));

        // Three words with a two-cycle hold right after the first issue.
        for (int i = 0; i < 3; i++) write_word(i, rand_word());
        write_word(3, 16'hC000);
        push_expected();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 5 && !issue_valid; n++) tick();
        check("hold_first_issue", issue_valid == 1'b1, "no first issue within budget, required one");
        hold = 1'b1;
        tick();
        check("hold_bubble_1", !issue_valid, "valid=1 under hold, required 0");
        tick();
        check("hold_bubble_2", !issue_valid && busy, $sformatf("valid=%0d busy=%0d, required 0 1", issue_valid, busy));
        hold = 1'b0;
        tick();
        check("resume_after_hold", issue_valid == 1'b1, "valid=0 after hold released, required 1");
        wait_done(0, 1'b0);
        tick();

        // Random programs with random holds; word 0 rewritten on the start edge.
        for (int it = 0; it < 6; it++) begin
            len = (it == 0) ? 0 : $urandom_range(16);
            for (int i = 0; i < DEPTH; i++) write_word(i, rand_word());
            if (len < DEPTH) write_word(len, rand_word() | 16'h4000);
            w = (len == 0) ? 16'h4000 : rand_word();
            model_mem[0] = w;
            push_expected();
            prog_we = 1'b1; prog_addr = 4'd0; prog_data = w; start = 1'b1;
            tick();
            prog_we = 1'b0; start = 1'b0;
            wait_done(30, 1'b0);
            tick();
        end

        // Writes and start during RUN are dropped; a re-run sees the original store.
        for (int i = 0; i < 6; i++) write_word(i, rand_word());
        write_word(6, 16'h4000);
        push_expected();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        hold = 1'b1;
        prog_we = 1'b1; prog_addr = 4'd1; prog_data = ~model_mem[1] & 16'hBFFF; start = 1'b1;
        tick();
        prog_we = 1'b0; start = 1'b0;
        tick();
        hold = 1'b0;
        wait_done(0, 1'b0);
        tick();
        run_program(0, 1'b0);

        // Reset mid-run aborts without done; store survives.
        for (int i = 0; i < 10; i++) write_word(i, rand_word());
        write_word(10, 16'h4000);
        push_expected();
        i0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1; start = 1'b1; hold = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0; hold = 1'b0;
        exp_q.delete();
        check_idle("reset_mid_run");
        repeat (3) tick();
        check("no_done_after_abort", done_cnt == i0,
              $sformatf("done pulses=%0d, required 0", done_cnt - i0));
        i0 = issue_cnt;
        run_program(0, 1'b0);
        check("store_kept_over_reset", issue_cnt - i0 == 10,
              $sformatf("issued %0d, required 10", issue_cnt - i0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
